// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ADDR_W      = 10;

  // One fetch-queue entry: byte address plus the word read from the ROM.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Clears the two low address bits so every fetch is word aligned.
  function automatic logic [ADDR_W-1:0] align4(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO of fetch entries with a single-cycle flush.
// The head entry is read straight from the storage registers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overflow/underflow even if the caller misbehaves.
  always_comb begin
    push_ok = push && (count != CNT_W'(DEPTH));
    pop_ok  = pop && (count != '0);
  end

  // Storage, pointers and occupancy; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through the ROM, queues each
// word and hands {pc, instr} to decode over valid/ready. Supports redirect
// and end-of-trace stop. Optional performance counters are enabled by
// defining FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned TRACE_END = 48,
  parameter int unsigned FQ_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic               trace_done
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
  output logic [15:0]        perf_redirects
`endif
);

  // One extra pc bit so a trace ending at the top of the ROM is representable.
  localparam int unsigned PC_W  = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] END_PC     = PC_W'(TRACE_END);

  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] count;
  logic             fetch_en_c;
  logic             pop_c;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Fetch only below the trace end, into a queue not already full.
  always_comb begin
    fetch_en_c = (pc < END_PC) && (count < CNT_W'(FQ_DEPTH)) && !redirect_valid;
    pop_c      = out_valid && out_ready && !redirect_valid;
    push_entry = '{pc: pc[ADDR_W-1:0], instr: rom_data};
  end

  // PC register: redirect wins, otherwise advance one word per push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC_V;
    else if (redirect_valid) pc <= {1'b0, align4(redirect_pc)};
    else if (fetch_en_c)     pc <= pc + PC_W'(INSTR_BYTES);
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (fetch_en_c),
    .wdata (push_entry),
    .pop   (pop_c),
    .head  (head),
    .count (count)
  );

  // Decode-side outputs come straight from registered queue state.
  always_comb begin
    rom_addr   = pc[ADDR_W-1:0];
    out_valid  = (count != '0);
    out_pc     = head.pc;
    out_instr  = head.instr;
    trace_done = (pc >= END_PC) && (count == '0);
  end

`ifdef FETCH_CTRL_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_stall     <= '0;
      perf_redirects <= '0;
    end else begin
      if (fetch_en_c && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && !out_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
      if (redirect_valid && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (default parameters).
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        out_ready;
  logic        trace_done;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [15:0] perf_redirects;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .trace_done     (trace_done)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_redirects (perf_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: byte at address a holds a[7:0].
  function automatic logic [31:0] word_at(input logic [9:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)};
  endfunction

  always_comb rom_data = word_at(rom_addr);

  // Advance one clock; sample/drive point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    checks++; if (out_pc !== 10'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    checks++; if (trace_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", trace_done); end
    checks++; if (rom_addr !== 10'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
  endtask

  task automatic test_stream();
    logic [9:0] exp_pc;
    out_ready = 1'b1;
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_pre_valid got=%0b exp=0", out_valid); end
    for (int i = 0; i < 12; i++) begin
      step();
      exp_pc = 10'(4 * i);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc) || trace_done !== 1'b0) begin
        failures++;
        $display("FAIL stream_word[%0d] got v=%0b pc=%h instr=%h done=%0b exp v=1 pc=%h instr=%h done=0",
                 i, out_valid, out_pc, out_instr, trace_done, exp_pc, word_at(exp_pc));
      end
      if (i == 0) begin
        checks++; if (out_instr !== 32'h00010203) begin failures++; $display("FAIL stream_first_instr got=%h exp=00010203", out_instr); end
      end
      if (i == 11) begin
        checks++; if (out_instr !== 32'h2C2D2E2F) begin failures++; $display("FAIL stream_last_instr got=%h exp=2c2d2e2f", out_instr); end
      end
    end
    step();
    checks++; if (trace_done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_done got done=%0b v=%0b exp done=1 v=0", trace_done, out_valid); end
  endtask

  task automatic test_stall();
    logic [9:0] exp_pc;
    out_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 10'h0 || out_instr !== 32'h00010203) begin
        failures++;
        $display("FAIL stall_head[%0d] got v=%0b pc=%h instr=%h exp v=1 pc=000 instr=00010203", i, out_valid, out_pc, out_instr);
      end
    end
    checks++; if (rom_addr !== 10'd16) begin failures++; $display("FAIL stall_rom_addr got=%0d exp=16", rom_addr); end
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      exp_pc = 10'(4 + 4 * k);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin
        failures++;
        $display("FAIL stall_release[%0d] got v=%0b pc=%h instr=%h exp v=1 pc=%h", k, out_valid, out_pc, out_instr, exp_pc);
      end
    end
    step();
    checks++; if (trace_done !== 1'b1) begin failures++; $display("FAIL stall_done got=%0b exp=1", trace_done); end
`ifdef FETCH_CTRL_PERF_EN
    checks++; if (perf_fetched !== 32'd12) begin failures++; $display("FAIL perf_fetched got=%0d exp=12", perf_fetched); end
    checks++; if (perf_stall !== 32'd9) begin failures++; $display("FAIL perf_stall got=%0d exp=9", perf_stall); end
    checks++; if (perf_redirects !== 16'd0) begin failures++; $display("FAIL perf_redirects got=%0d exp=0", perf_redirects); end
`endif
  endtask

  task automatic test_redirect();
    logic [9:0] exp_pc;
    out_ready = 1'b0;
    apply_reset();
    repeat (4) step();
    // Queue holds 0..12; redirect with a live handshake on the head.
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h01F;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || rom_addr !== 10'h01C) begin failures++; $display("FAIL redir_flush got v=%0b addr=%h exp v=0 addr=01c", out_valid, rom_addr); end
    for (int k = 0; k < 5; k++) begin
      step();
      exp_pc = 10'(28 + 4 * k);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin
        failures++;
        $display("FAIL redir_seq[%0d] got v=%0b pc=%h instr=%h exp v=1 pc=%h", k, out_valid, out_pc, out_instr, exp_pc);
      end
    end
    step();
    checks++; if (trace_done !== 1'b1) begin failures++; $display("FAIL redir_done1 got=%0b exp=1", trace_done); end
    redirect_valid = 1'b1;
    redirect_pc = 10'd40;
    step();
    redirect_valid = 1'b0;
    checks++; if (trace_done !== 1'b0) begin failures++; $display("FAIL redir40_done_clear got=%0b exp=0", trace_done); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'd40) begin failures++; $display("FAIL redir40_w40 got v=%0b pc=%0d exp v=1 pc=40", out_valid, out_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'd44 || out_instr !== 32'h2C2D2E2F) begin failures++; $display("FAIL redir40_w44 got v=%0b pc=%0d instr=%h exp pc=44", out_valid, out_pc, out_instr); end
    step();
    checks++; if (trace_done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL redir40_done got done=%0b v=%0b exp done=1 v=0", trace_done, out_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 10'd48;
    step();
    redirect_valid = 1'b0;
    checks++; if (trace_done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL redir48_done got done=%0b v=%0b exp done=1 v=0", trace_done, out_valid); end
    step();
    step();
    checks++; if (out_valid !== 1'b0 || rom_addr !== 10'd48) begin failures++; $display("FAIL redir48_idle got v=%0b addr=%0d exp v=0 addr=48", out_valid, rom_addr); end
`ifdef FETCH_CTRL_PERF_EN
    checks++; if (perf_redirects !== 16'd3) begin failures++; $display("FAIL perf_redirects3 got=%0d exp=3", perf_redirects); end
`endif
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    apply_reset();
    repeat (5) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'd16) begin failures++; $display("FAIL async_pre got v=%0b pc=%0d exp v=1 pc=16", out_valid, out_pc); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || rom_addr !== 10'h0 || trace_done !== 1'b0) begin failures++; $display("FAIL async_assert got v=%0b addr=%h done=%0b exp v=0 addr=0 done=0", out_valid, rom_addr, trace_done); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'h0 || out_instr !== 32'h00010203) begin failures++; $display("FAIL async_restart0 got v=%0b pc=%h instr=%h exp v=1 pc=0", out_valid, out_pc, out_instr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 10'd4) begin failures++; $display("FAIL async_restart4 got v=%0b pc=%0d exp v=1 pc=4", out_valid, out_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
